// File: rtl/frame_buffer_arbiter_if.sv
// Writer, VGA reader and RAM port bundle of the frame-buffer arbiter.
// master = arbiter side, slave = environment (writer, reader, RAM).
interface frame_buffer_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int CNT_WIDTH  = 16
);
    logic                  start_i;
    logic                  wr_valid_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  wr_ready_o;
    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_valid_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  ram_en_o;
    logic                  ram_we_o;
    logic                  ram_re_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;
    logic                  frame_ready_o;
    logic                  wr_frame_done_o;
    logic [CNT_WIDTH-1:0]  conflict_cnt_o;

    modport master (
        input  start_i, wr_valid_i, wr_data_i, rd_req_i, rd_addr_i, ram_rdata_i,
        output wr_ready_o, rd_valid_o, rd_data_o, ram_en_o, ram_we_o, ram_re_o,
               ram_addr_o, ram_wdata_o, frame_ready_o, wr_frame_done_o, conflict_cnt_o
    );

    modport slave (
        output start_i, wr_valid_i, wr_data_i, rd_req_i, rd_addr_i, ram_rdata_i,
        input  wr_ready_o, rd_valid_o, rd_data_o, ram_en_o, ram_we_o, ram_re_o,
               ram_addr_o, ram_wdata_o, frame_ready_o, wr_frame_done_o, conflict_cnt_o
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer sequencer: initial full-frame fill, then
// interleaved writer/scan-out access with reads taking strict priority.
module frame_buffer_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int RAM_DEPTH  = 76800,
    parameter int CNT_WIDTH  = 16
) (
    input logic                   clk_i_arb,
    input logic                   rst_i_arb,
    frame_buffer_arbiter_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_sel;
    logic                  rd_valid;
    logic                  frame_done;
    logic                  frame_ready;
    logic [CNT_WIDTH-1:0]  conflict_cnt;

    logic wr_ready;
    logic wr_fire;
    logic wr_last;
    logic rd_hit;

    // Reads during IDLE/FILL or beyond the frame are answered with 0 and never reach the RAM.
    assign wr_ready = (state == FILL) || ((state == RUN) && !bus.rd_req_i);
    assign wr_fire  = bus.wr_valid_i && wr_ready;
    assign wr_last  = (wr_addr == LAST_ADDR);
    assign rd_hit   = (state == RUN) && bus.rd_req_i && (bus.rd_addr_i <= LAST_ADDR);

    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_re_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        if (rd_hit) begin
            bus.ram_en_o   = 1'b1;
            bus.ram_re_o   = 1'b1;
            bus.ram_addr_o = bus.rd_addr_i;
        end else if (wr_fire) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = 1'b1;
            bus.ram_addr_o  = wr_addr;
            bus.ram_wdata_o = bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i_arb) begin
        if (rst_i_arb) begin
            state        <= IDLE;
            wr_addr      <= '0;
            rd_valid     <= 1'b0;
            rd_sel       <= 1'b0;
            frame_done   <= 1'b0;
            frame_ready  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            rd_valid   <= bus.rd_req_i;
            rd_sel     <= rd_hit;
            frame_done <= wr_fire && wr_last;

            if (wr_fire)
                wr_addr <= wr_last ? '0 : wr_addr + 1'b1;

            case (state)
                IDLE: if (bus.start_i) state <= FILL;
                FILL: if (wr_fire && wr_last) begin
                    state       <= RUN;
                    frame_ready <= 1'b1;
                end
                RUN:  ;
                default: state <= IDLE;
            endcase

            if ((state == RUN) && bus.wr_valid_i && bus.rd_req_i && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign bus.wr_ready_o      = wr_ready;
    assign bus.rd_valid_o      = rd_valid;
    // Select is registered with the strobe so blank reads return 0 regardless of RAM output.
    assign bus.rd_data_o       = rd_sel ? bus.ram_rdata_i : '0;
    assign bus.frame_ready_o   = frame_ready;
    assign bus.wr_frame_done_o = frame_done;
    assign bus.conflict_cnt_o  = conflict_cnt;
endmodule
